reg_wb_arbiter: RTL and testbench

REG_WB_ARBITER -- requirements
Module: reg_wb_arbiter

---
 rtl/reg_wb_arbiter.sv | 101 ++++++++++
 tb/tb_reg_wb_arbiter.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/reg_wb_arbiter.sv
// Two-source writeback arbiter in front of a register file. It picks the ALU or
// the load unit round-robin, registers the write one cycle later, and tracks pending registers.
module reg_wb_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     aluValid,
    input  logic [ADDR_WIDTH-1:0]    aluRegister,
    input  logic [DATA_WIDTH-1:0]    aluData,
    output logic                     aluReady,
    input  logic                     memValid,
    input  logic [ADDR_WIDTH-1:0]    memRegister,
    input  logic [DATA_WIDTH-1:0]    memData,
    output logic                     memReady,
    input  logic                     reserveValid,
    input  logic [ADDR_WIDTH-1:0]    reserveRegister,
    output logic [2**ADDR_WIDTH-1:0] busyMask,
    output logic                     writeEnable,
    output logic [ADDR_WIDTH-1:0]    writeRegister,
    output logic [DATA_WIDTH-1:0]    writeData
);

    localparam int NUM_REGS = 2**ADDR_WIDTH;

    // Set when the most recent grant went to the load unit.
    logic                  last_grant_mem_q, last_grant_mem_d;
    logic                  write_enable_q, write_enable_d;
    logic [ADDR_WIDTH-1:0] write_register_q, write_register_d;
    logic [DATA_WIDTH-1:0] write_data_q, write_data_d;
    logic [NUM_REGS-1:0]   busy_q, busy_d;

    logic                  grant;
    logic [ADDR_WIDTH-1:0] grant_reg;
    logic [DATA_WIDTH-1:0] grant_data;

    // Readies depend only on the Valids and the pointer, never on the busy bits.
    always_comb begin
        aluReady = 1'b0;
        memReady = 1'b0;
        if (rst_n) begin
            aluReady = aluValid && (!memValid || last_grant_mem_q);
            memReady = memValid && (!aluValid || !last_grant_mem_q);
        end
    end

    always_comb begin
        grant      = aluReady || memReady;
        grant_reg  = memReady ? memRegister : aluRegister;
        grant_data = memReady ? memData     : aluData;
    end

    always_comb begin
        last_grant_mem_d = last_grant_mem_q;
        write_enable_d   = 1'b0;
        write_register_d = write_register_q;
        write_data_d     = write_data_q;
        if (grant) begin
            last_grant_mem_d = memReady;
            // Register 0 is hard-wired: the request is consumed but never written.
            write_enable_d   = (grant_reg != '0);
            write_register_d = grant_reg;
            write_data_d     = grant_data;
        end
    end

    // A reserve in the same cycle as a writeback to that index wins.
    always_comb begin
        busy_d = busy_q;
        if (grant) begin
            busy_d[grant_reg] = 1'b0;
        end
        if (reserveValid) begin
            busy_d[reserveRegister] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_mem_q <= 1'b1;
            write_enable_q   <= 1'b0;
            write_register_q <= '0;
            write_data_q     <= '0;
            busy_q           <= '0;
        end else begin
            last_grant_mem_q <= last_grant_mem_d;
            write_enable_q   <= write_enable_d;
            write_register_q <= write_register_d;
            write_data_q     <= write_data_d;
            busy_q           <= busy_d;
        end
    end

    assign writeEnable   = write_enable_q;
    assign writeRegister = write_register_q;
    assign writeData     = write_data_q;
    assign busyMask      = busy_q;

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Bench for reg_wb_arbiter: a table of per-cycle requests with expected readies,
// a queue of expected writeback results, and hand-written reset sequences.
module tb_reg_wb_arbiter;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 2**AW;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          aluValid, memValid, reserveValid;
    logic [AW-1:0] aluRegister, memRegister, reserveRegister;
    logic [DW-1:0] aluData, memData;
    logic          aluReady, memReady;
    logic [NR-1:0] busyMask;
    logic          writeEnable;
    logic [AW-1:0] writeRegister;
    logic [DW-1:0] writeData;

    reg_wb_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .aluValid(aluValid), .aluRegister(aluRegister), .aluData(aluData), .aluReady(aluReady),
        .memValid(memValid), .memRegister(memRegister), .memData(memData), .memReady(memReady),
        .reserveValid(reserveValid), .reserveRegister(reserveRegister),
        .busyMask(busyMask), .writeEnable(writeEnable),
        .writeRegister(writeRegister), .writeData(writeData)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          av;
        logic [AW-1:0] ar;
        logic [DW-1:0] ad;
        logic          mv;
        logic [AW-1:0] mr;
        logic [DW-1:0] md;
        logic          rv;
        logic [AW-1:0] rr;
        logic          ea;
        logic          em;
    } vec_t;

    typedef struct {
        logic          we;
        logic [AW-1:0] wr;
        logic [DW-1:0] wd;
        logic [NR-1:0] busy;
    } exp_t;

    exp_t          sb[$];
    int            n_cmp  = 0;
    int            n_fail = 0;
    logic [AW-1:0] m_reg;
    logic [DW-1:0] m_data;
    logic [NR-1:0] m_busy;

    function automatic vec_t mk(input logic av, input int ar, input logic [DW-1:0] ad,
                                input logic mv, input int mr, input logic [DW-1:0] md,
                                input logic rv, input int rr, input logic ea, input logic em);
        vec_t v;
        v.av = av; v.ar = AW'(ar); v.ad = ad;
        v.mv = mv; v.mr = AW'(mr); v.md = md;
        v.rv = rv; v.rr = AW'(rr);
        v.ea = ea; v.em = em;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        aluValid = v.av; aluRegister = v.ar; aluData = v.ad;
        memValid = v.mv; memRegister = v.mr; memData = v.md;
        reserveValid = v.rv; reserveRegister = v.rr;
    endtask

    // Starts and ends at a falling edge: checks readies, predicts, clocks, compares.
    task automatic step(input vec_t v, input string tag);
        exp_t          e;
        exp_t          got;
        logic          g;
        logic [AW-1:0] idx;
        drive(v);
        #1;
        chk({tag, " aluReady"}, 64'(aluReady), 64'(v.ea));
        chk({tag, " memReady"}, 64'(memReady), 64'(v.em));
        g   = v.ea || v.em;
        idx = v.em ? v.mr : v.ar;
        if (g) begin
            m_reg  = idx;
            m_data = v.em ? v.md : v.ad;
            m_busy[idx] = 1'b0;
        end
        if (v.rv && v.rr != '0) m_busy[v.rr] = 1'b1;
        e.we = g && (idx != '0);
        e.wr = m_reg; e.wd = m_data; e.busy = m_busy;
        sb.push_back(e);
        @(negedge clk);
        if (sb.size() == 0) begin
            chk({tag, " scoreboard empty"}, 64'd1, 64'd0);
        end else begin
            got = sb.pop_front();
            chk({tag, " writeEnable"},   64'(writeEnable),   64'(got.we));
            chk({tag, " writeRegister"}, 64'(writeRegister), 64'(got.wr));
            chk({tag, " writeData"},     64'(writeData),     64'(got.wd));
            chk({tag, " busyMask"},      64'(busyMask),      64'(got.busy));
        end
        $display("step %-12s ar=%0b mr=%0b we=%0b wr=%0d wd=%h busy=%h", tag,
                 aluReady, memReady, writeEnable, writeRegister, writeData, busyMask);
    endtask

    task automatic model_reset();
        sb.delete();
        m_reg = '0; m_data = '0; m_busy = '0;
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, " writeEnable"},   64'(writeEnable),   64'd0);
        chk({tag, " writeRegister"}, 64'(writeRegister), 64'd0);
        chk({tag, " writeData"},     64'(writeData),     64'd0);
        chk({tag, " busyMask"},      64'(busyMask),      64'd0);
        chk({tag, " aluReady"},      64'(aluReady),      64'd0);
        chk({tag, " memReady"},      64'(memReady),      64'd0);
    endtask

    vec_t vecs[16];
    vec_t idle;

    initial begin
        idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        vecs[0]  = mk(1, 5, 32'hDEADBEEF, 0, 0, 0,           0, 0, 1, 0);
        vecs[1]  = idle;
        vecs[2]  = mk(0, 0, 0,            1, 3, 32'h33,      0, 0, 0, 1);
        vecs[3]  = mk(1, 1, 32'hA1,       1, 2, 32'hB2,      0, 0, 1, 0);
        vecs[4]  = mk(1, 1, 32'hA2,       1, 2, 32'hB3,      0, 0, 0, 1);
        vecs[5]  = mk(1, 1, 32'hA3,       1, 2, 32'hB4,      0, 0, 1, 0);
        vecs[6]  = mk(1, 1, 32'hA4,       1, 2, 32'hB5,      0, 0, 0, 1);
        vecs[7]  = idle;
        vecs[8]  = mk(0, 0, 0,            0, 0, 0,           1, 7, 0, 0);
        vecs[9]  = mk(0, 0, 0,            1, 7, 32'h77,      0, 0, 0, 1);
        vecs[10] = mk(1, 9, 32'h99,       0, 0, 0,           1, 9, 1, 0);
        vecs[11] = mk(1, 0, 32'h1234,     0, 0, 0,           0, 0, 1, 0);
        vecs[12] = mk(0, 0, 0,            0, 0, 0,           1, 0, 0, 0);
        vecs[13] = mk(1, 6, 32'h66,       1, 8, 32'h88,      0, 0, 0, 1);
        vecs[14] = mk(0, 0, 0,            1, 12, 32'hC,      0, 0, 0, 1);
        vecs[15] = mk(0, 0, 0,            1, 9, 32'h9,       0, 0, 0, 1);

        // Reset with requests pending: readies must stay low.
        rst_n = 1'b0;
        drive(mk(1, 3, 32'h5, 1, 4, 32'h6, 1, 3, 0, 0));
        model_reset();
        #12;
        check_reset_state("reset");
        @(negedge clk);
        drive(idle);
        rst_n = 1'b1;

        for (int i = 0; i < 16; i++) begin
            step(vecs[i], $sformatf("vec%0d", i));
        end

        // Leave a write in flight and register 7 reserved, then reset mid-cycle.
        step(mk(1, 4, 32'h44, 0, 0, 0, 1, 7, 1, 0), "pre_reset");
        chk("pre_reset busy7", 64'(busyMask), 64'h80);
        drive(mk(1, 10, 32'hAA, 1, 11, 32'hBB, 0, 0, 0, 0));
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_state("async_reset");
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        step(mk(1, 10, 32'hAA, 1, 11, 32'hBB, 0, 0, 1, 0), "post_rst_c1");
        step(mk(1, 10, 32'hAC, 1, 11, 32'hBD, 0, 0, 0, 1), "post_rst_c2");
        step(idle, "final_idle");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
